// File: rtl/bus_pkg.sv
// bus_pkg: state encoding and error read data shared by the bus slave memory.
package bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_e;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/bus_mem_array.sv
// bus_mem_array: DEPTH x 32 storage, synchronous write, registered read port.
module bus_mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_d, rdata_q;
    always_comb rdata_d = re ? mem_q[addr] : rdata_q;
    // Storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk)
        if (we) mem_q[addr] <= wdata;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    assign rdata = rdata_q;
endmodule

// File: rtl/bus_slave_mem.sv
// bus_slave_mem: req/gnt bus slave with programmable wait states in front of a word memory.
module bus_slave_mem
    import bus_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    output logic        gnt,
    output logic [31:0] rdata
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        in_range, enter_gnt;
    logic [31:0] mem_rdata;
    always_comb begin
        in_range  = 32'(addr) < DEPTH;
        enter_gnt = state_q == WAIT && req && cnt_q == 4'd0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
            end
            WAIT: begin
                state_d = !req ? IDLE : cnt_q == 4'd0 ? GRANT : WAIT;
                cnt_d   = req && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
            end
            default: state_d = IDLE;
        endcase
        // Out-of-range reads latch a flag so ERR_DATA holds until the next read.
        err_d = enter_gnt && !wr_en ? !in_range : err_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    bus_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (enter_gnt && wr_en && in_range),
        .re    (enter_gnt && !wr_en && in_range),
        .addr  (addr[AW-1:0]),
        .wdata (wdata),
        .rdata (mem_rdata)
    );
    assign gnt   = state_q == GRANT;
    assign rdata = err_q ? ERR_DATA : mem_rdata;
endmodule

// File: tb/tb_bus_slave_mem.sv
// tb_bus_slave_mem: directed checks of two slaves, WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_bus_slave_mem;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req2 = 1'b0, wr2 = 1'b0, gnt2;
    logic [7:0]  addr2 = '0;
    logic [31:0] wdata2 = '0, rdata2;
    logic        req0 = 1'b0, wr0 = 1'b0, gnt0;
    logic [7:0]  addr0 = '0;
    logic [31:0] wdata0 = '0, rdata0;
    int checks = 0, failures = 0;
    int k, n;
    logic [31:0] rd, prev;

    always #5 clk = ~clk;

    bus_slave_mem #(.DEPTH(64), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .addr(addr2), .wdata(wdata2),
        .wr_en(wr2), .gnt(gnt2), .rdata(rdata2)
    );
    bus_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .addr(addr0), .wdata(wdata0),
        .wr_en(wr0), .gnt(gnt0), .rdata(rdata0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Returns the number of rising edges from the first edge after the command
    // is driven until gnt is seen (99 on timeout). A fresh request waits out
    // any GRANT cycle first; a held request is re-driven during GRANT.
    task automatic xfer(input bit z, input logic [7:0] a, input logic [31:0] d,
                        input bit w, input bit keep, output int edges, output logic [31:0] r);
        bit g;
        repeat ((z ? req0 : req2) ? 1 : 2) @(negedge clk);
        if (z) begin req0 = 1'b1; addr0 = a; wdata0 = d; wr0 = w; end
        else   begin req2 = 1'b1; addr2 = a; wdata2 = d; wr2 = w; end
        edges = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            g = z ? gnt0 : gnt2;
            if (g) begin
                edges = i;
                break;
            end
        end
        r = z ? rdata0 : rdata2;
        if (!keep) begin
            if (z) req0 = 1'b0;
            else   req2 = 1'b0;
        end
    endtask

    initial begin
        #1;
        check("rst_gnt2", 32'(gnt2), 32'd0);
        check("rst_rdata2", rdata2, 32'd0);
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // WAIT_CYCLES=2: gnt lands on the 4th edge (sampling edge + 3)
        xfer(0, 8'h05, 32'h1234_5678, 1, 0, k, rd);
        check("wr_lat", k, 4);
        check("wr_rdata_hold", rd, 32'd0);
        xfer(0, 8'h05, 32'h0, 0, 0, k, rd);
        check("rd_lat", k, 4);
        check("rd_05", rd, 32'h1234_5678);
        xfer(0, 8'h00, 32'h0A0A_0A0A, 1, 0, k, rd);
        xfer(0, 8'h3F, 32'h6363_6363, 1, 0, k, rd);
        xfer(0, 8'h80, 32'hBAD0_BAD0, 1, 0, k, rd);
        check("oor_wr_lat", k, 4);
        xfer(0, 8'h45, 32'hBAD1_BAD1, 1, 0, k, rd);
        xfer(0, 8'h00, 32'h0, 0, 0, k, rd);
        check("rd_00", rd, 32'h0A0A_0A0A);
        xfer(0, 8'h3F, 32'h0, 0, 0, k, rd);
        check("rd_3f", rd, 32'h6363_6363);
        xfer(0, 8'h05, 32'h0, 0, 0, k, rd);
        check("rd_05_alias", rd, 32'h1234_5678);
        xfer(0, 8'h80, 32'h0, 0, 0, k, rd);
        check("oor_rd_lat", k, 4);
        check("oor_rd_80", rd, 32'hDEAD_BEEF);
        xfer(0, 8'h06, 32'h55AA_55AA, 1, 0, k, rd);
        check("wr_keeps_err", rd, 32'hDEAD_BEEF);
        xfer(0, 8'hFF, 32'h0, 0, 0, k, rd);
        check("oor_rd_ff", rd, 32'hDEAD_BEEF);
        xfer(0, 8'h06, 32'h0, 0, 0, k, rd);
        check("rd_06", rd, 32'h55AA_55AA);

        // abort: req dropped the cycle after it was sampled
        prev = rdata2;
        repeat (2) @(negedge clk);
        req2 = 1'b1; addr2 = 8'h05; wdata2 = 32'hCAFE_CAFE; wr2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0;
        n = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (gnt2) n++;
        end
        check("abort_gnt", n, 0);
        check("abort_rdata", rdata2, prev);
        xfer(0, 8'h05, 32'h0, 0, 0, k, rd);
        check("abort_no_wr", rd, 32'h1234_5678);

        // held req: second transfer follows at WAIT_CYCLES+3 spacing
        xfer(0, 8'h07, 32'h0000_0007, 1, 1, k, rd);
        xfer(0, 8'h07, 32'h0, 0, 0, k, rd);
        check("held_spacing", k, 5);
        check("held_rd_07", rd, 32'h0000_0007);

        // WAIT_CYCLES=0: fresh gnt on 2nd edge, back-to-back every 3 edges
        xfer(1, 8'h0A, 32'h1111_2222, 1, 1, k, rd);
        check("w0_wr_lat", k, 2);
        xfer(1, 8'h0A, 32'h0, 0, 1, k, rd);
        check("w0_b2b_rd_lat", k, 3);
        check("w0_rd_0a", rd, 32'h1111_2222);
        xfer(1, 8'h0B, 32'h3333_4444, 1, 1, k, rd);
        check("w0_b2b_wr_lat", k, 3);
        xfer(1, 8'h0B, 32'h0, 0, 0, k, rd);
        check("w0_b2b_rd2_lat", k, 3);
        check("w0_rd_0b", rd, 32'h3333_4444);

        // reset while in WAIT
        repeat (2) @(negedge clk);
        req2 = 1'b1; addr2 = 8'h05; wdata2 = 32'h7777_7777; wr2 = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstw_gnt", 32'(gnt2), 32'd0);
        check("rstw_rdata", rdata2, 32'd0);
        req2 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 8'h05, 32'h0, 0, 0, k, rd);
        check("rstw_lat", k, 4);
        check("rstw_no_wr", rd, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
